// File: rtl/load_store_unit.sv
// Memory-side load/store stage: req/ack bus handshake with byte-lane steering, alignment checks and load extension.
// Optional LSU_TIMEOUT_EN: abort a request that sees no bus_ack within TIMEOUT cycles.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        access;
  logic        legal;
  logic        aligned;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT must be >= 1");
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  assign access = MemRead | MemWrite;
  assign off    = ALUResult[1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    be_d    = 4'b1111;
    wdata_d = WriteData;
    // A store is any access with MemWrite set, even when MemRead is also high.
    if (MemWrite) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << off;
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        aligned = ~off[0];
        be_d    = 4'b0011 << off;
        wdata_d = {2{WriteData[15:0]}};
      end
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*o +: 8];
    h = o[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign Stall = ((state == IDLE) && access) || (state == REQ);

  // NOTE: sequential state uses non-blocking assignments only; bus outputs are registered
  // and cleared by the asynchronous reset so a mid-transaction reset drops bus_req at once.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
      Fault     <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      Fault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (legal && aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_addr  <= {ALUResult[31:2], 2'b00};
              bus_be    <= be_d;
              bus_wdata <= wdata_d;
              f3_q      <= funct3;
              off_q     <= off;
`ifdef LSU_TIMEOUT_EN
              wait_cnt  <= '0;
`endif
              state     <= REQ;
            end else begin
              Fault    <= 1'b1;
              ReadData <= '0;
              state    <= DONE;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            ReadData <= bus_we ? 32'd0 : load_extract(f3_q, off_q, bus_rdata);
            state    <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          // wait_cnt counts completed ack-less REQ cycles; the TIMEOUT-th one aborts.
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            bus_req  <= 1'b0;
            Fault    <= 1'b1;
            ReadData <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a byte-level model.
// Acts as the bus slave with a random ack delay; exercises the LSU_TIMEOUT_EN abort when that macro is defined.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Fault(Fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: an access covers `size` bytes starting at byte offset addr%4.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic legal, output logic [3:0] ebe,
                                output logic [31:0] ewd, output logic [31:0] erd);
    int size, o;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    o     = int'(addr[1:0]);
    legal = (wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) && (o % size == 0);
    ebe = '0;
    ewd = '0;
    erd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= o && i < o + size) ebe[i] = 1'b1;
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    if (legal && !wr) begin
      v = word >> (8 * o);
      if (size < 4) begin
        v = v & ((32'd1 << (8 * size)) - 32'd1);
        if (!f3[2] && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      end
      erd = v;
    end
  endfunction

  // Starts #1 after a rising edge with the DUT idle; returns #1 after a rising edge, idle again.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] word);
    logic legal;
    logic [3:0] ebe;
    logic [31:0] ewd, erd;
    model(wr, f3, addr, wd, word, legal, ebe, ewd, erd);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
    #1;
    check("stall_idle_access", Stall, 1);
    @(posedge CLK); #1;
    if (!legal) begin
      check("fault_done", Fault, 1);
      check("fault_rdata", ReadData, 0);
      check("fault_no_req", bus_req, 0);
      check("fault_stall", Stall, 0);
    end else begin
      check("req_bus_req", bus_req, 1);
      check("req_we", bus_we, wr);
      check("req_addr", bus_addr, {addr[31:2], 2'b00});
      check("req_be", bus_be, ebe);
      if (wr) check("req_wdata", bus_wdata, ewd);
      check("req_stall", Stall, 1);
      for (int i = 0; i < delay; i++) begin
        @(posedge CLK); #1;
        check("req_hold", bus_req, 1);
        check("req_hold_stall", Stall, 1);
      end
      bus_ack = 1'b1; bus_rdata = word;
      @(posedge CLK); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
      check("done_rdata", ReadData, erd);
      check("done_fault", Fault, 0);
      check("done_req_low", bus_req, 0);
      check("done_stall", Stall, 0);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge CLK); #1;
    check("idle_fault_clear", Fault, 0);
    check("idle_stall", Stall, 0);
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0;
    ALUResult = '0; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_rdata", ReadData, 0);
    check("rst_fault", Fault, 0);
    check("rst_stall", Stall, 0);
    reset = 1'b1;
    @(posedge CLK); #1;

    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);      // LW
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000);     // LB
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000);     // LBU
    run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 2, 32'h5555);   // SH
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0);             // misaligned LW
    run_access(1, 0, 3'b001, 32'h203, 32'h0, 0, 32'h0);             // misaligned LH
    run_access(1, 0, 3'b011, 32'h200, 32'h0, 0, 32'h0);             // illegal load funct3
    run_access(0, 1, 3'b100, 32'h200, 32'h0, 0, 32'h0);             // illegal store funct3
    run_access(1, 1, 3'b000, 32'h301, 32'hA5, 0, 32'hFFFF_FFFF);    // both set: store
    run_access(1, 0, 3'b101, 32'h302, 32'h0, 3, 32'h8001_7FFF);     // LHU upper half

    // bus_ack while idle is ignored
    bus_ack = 1'b1;
    @(posedge CLK); #1;
    bus_ack = 1'b0;
    check("idle_ack_no_req", bus_req, 0);
    check("idle_ack_no_fault", Fault, 0);

    // reset asserted mid-REQ
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h400;
    @(posedge CLK); #1;
    check("mid_rst_req_before", bus_req, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_drop", bus_req, 0);
    check("mid_rst_stall_access", Stall, 1);
    MemRead = 1'b0;
    #1;
    check("mid_rst_stall_noaccess", Stall, 0);
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_no_fault", Fault, 0);
    check("mid_rst_no_rdata", ReadData, 0);

    for (int n = 0; n < 60; n++) begin
      logic rd, wr;
      int sel;
      sel = int'($urandom_range(0, 2));
      rd = (sel != 1);
      wr = (sel != 0);
      run_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                 int'($urandom_range(0, 3)), $urandom);
    end

`ifdef LSU_TIMEOUT_EN
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h500;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", bus_req, 1);
      @(posedge CLK); #1;
    end
    check("to_req_dropped", bus_req, 0);
    check("to_fault", Fault, 1);
    check("to_rdata", ReadData, 0);
    MemRead = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    bus_ack = 1'b0;
    check("to_late_ack_req", bus_req, 0);
    check("to_late_ack_fault", Fault, 0);
    check("to_late_ack_stall", Stall, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
